sram_port_arbiter: RTL and testbench

- Shares one single-ported synchronous SRAM between the instruction-fetch requester and the load/store requester of the pipelined core.
- Both requesters use a req/addr_ok/data_ok handshake.
- The arbiter makes one grant per cycle, tracks the single in-flight response, and returns data_ok to the correct owner one cycle after its grant.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/sram_port_arbiter_pkg.sv | 21 ++
 rtl/sram_port_arbiter.sv | 103 ++++++++++
 tb/tb_sram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store SRAM arbiter and the pipeline
// stages that talk to it through the req/addr_ok/data_ok handshake.
package sram_port_arbiter_pkg;

    // Response owner encoding carried in the one-stage response register.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_CNT_W   = 4;

    // Field widths shared by the fetch stage, the LSU and the arbiter.
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W_DEF = DATA_W_DEF / 8;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and
// load/store, one grant per cycle, with a starvation guard for fetch.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic                          inst_req,
    input  logic [ADDR_W-1:0]             inst_addr,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [DATA_W-1:0]             inst_rdata,

    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [strb_width(DATA_W)-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]             data_addr,
    input  logic [DATA_W-1:0]             data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [DATA_W-1:0]             data_rdata,

    output logic                          sram_en,
    output logic [strb_width(DATA_W)-1:0] sram_we,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [DATA_W-1:0]             sram_rdata
);

    localparam int STRB_W = strb_width(DATA_W);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    // Handshake: a requester raises *_req with stable fields and holds them
    // until *_addr_ok; the request is accepted in that same cycle. Exactly one
    // cycle later *_data_ok pulses for it. There is no back-pressure on
    // *_data_ok, so a requester must always consume the response.

    logic                    run;
    logic                    resp_valid;
    logic                    resp_owner;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    starved;
    logic                    grant_i;
    logic                    grant_d;

    // Grant selection: data first unless fetch has waited STARVE_MAX grants.
    always_comb begin
        starved = (starve_cnt == STARVE_LIM);
        grant_i = run & inst_req & (~data_req | starved);
        grant_d = run & data_req & ~grant_i;
    end

    always_comb begin
        sram_en    = grant_i | grant_d;
        sram_addr  = '0;
        sram_we    = '0;
        sram_wdata = data_wdata;
        if (grant_i) begin
            sram_addr = inst_addr;
        end else if (grant_d) begin
            sram_addr = data_addr;
            sram_we   = data_wr ? data_wstrb : STRB_W'(0);
        end
    end

    assign inst_addr_ok = grant_i;
    assign data_addr_ok = grant_d;

    assign inst_data_ok = resp_valid & (resp_owner == OWNER_INST);
    assign data_data_ok = resp_valid & (resp_owner == OWNER_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    // run gates grants for the first cycle after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run        <= 1'b0;
            resp_valid <= 1'b0;
            resp_owner <= OWNER_INST;
        end else begin
            run        <= 1'b1;
            resp_valid <= sram_en;
            resp_owner <= grant_d ? OWNER_DATA : OWNER_INST;
        end
    end

    // Counts data grants only while fetch is actually waiting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (grant_i || !inst_req) begin
            starve_cnt <= '0;
        end else if (grant_d && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter with an SRAM model and
// a request-level reference model of grants, responses and memory contents.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [SW-1:0] data_wstrb = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          sram_en;
    logic [SW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] dflt_word(input logic [29:0] idx);
        return {idx, 2'b00} ^ 32'h5a5a_a5a5;
    endfunction

    // SRAM model: synchronous read of the old word, byte-masked write.
    logic [31:0] mem_a [logic [29:0]];
    logic [31:0] sram_w;
    always @(posedge clk) begin
        if (sram_en) begin
            sram_w = mem_a.exists(sram_addr[31:2]) ? mem_a[sram_addr[31:2]]
                                                   : dflt_word(sram_addr[31:2]);
            sram_rdata <= sram_w;
            for (int b = 0; b < SW; b++)
                if (sram_we[b]) sram_w[8*b +: 8] = sram_wdata[8*b +: 8];
            mem_a[sram_addr[31:2]] = sram_w;
        end
    end

    // Reference model state: shadow memory, fetch wait streak, response queue.
    logic [31:0] ref_mem [logic [29:0]];
    int          streak = 0;
    bit          run_m = 1'b0;
    logic [33:0] exp_q[$];   // {owner_is_data, check_data, data}
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt_word(a[31:2]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check at negedge+1, advance to next negedge.
    task automatic step(input bit ireq, input logic [31:0] iaddr,
                        input bit dreq, input bit dwr, input logic [3:0] dstrb,
                        input logic [31:0] daddr, input logic [31:0] dwdata,
                        output bit oi, output bit od, output bit ook,
                        output logic [31:0] rd);
        logic [33:0] e;
        logic [31:0] w;
        bit          ei;
        bit          ed;
        inst_req = ireq; inst_addr = iaddr;
        data_req = dreq; data_wr = dwr; data_wstrb = dstrb;
        data_addr = daddr; data_wdata = dwdata;
        #1;
        rd  = data_rdata;
        ook = inst_data_ok | data_data_ok;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("inst_data_ok", inst_data_ok, !e[33]);
            chk("data_data_ok", data_data_ok, e[33]);
            rd = e[33] ? data_rdata : inst_rdata;
            if (e[32]) chk("rdata", rd, e[31:0]);
        end else begin
            chk("idle_inst_data_ok", inst_data_ok, 1'b0);
            chk("idle_data_data_ok", data_data_ok, 1'b0);
        end
        // Fetch wins only once it has watched SMAX data grants go by.
        ei = run_m && ireq && (!dreq || streak >= SMAX);
        ed = run_m && dreq && !ei;
        chk("inst_addr_ok", inst_addr_ok, ei);
        chk("data_addr_ok", data_addr_ok, ed);
        chk("sram_en", sram_en, ei || ed);
        chk("sram_addr", sram_addr, ei ? iaddr : (ed ? daddr : 32'h0));
        chk("sram_we", sram_we, (ed && dwr) ? dstrb : 4'h0);
        if (ed && dwr) chk("sram_wdata", sram_wdata, dwdata);
        oi = inst_addr_ok;
        od = data_addr_ok;
        if (ei) exp_q.push_back({1'b0, 1'b1, ref_rd(iaddr)});
        if (ed) begin
            if (dwr) begin
                w = ref_rd(daddr);
                for (int b = 0; b < 4; b++)
                    if (dstrb[b]) w[8*b +: 8] = dwdata[8*b +: 8];
                ref_mem[daddr[31:2]] = w;
                exp_q.push_back({1'b1, 1'b0, 32'h0});
            end else begin
                exp_q.push_back({1'b1, 1'b1, ref_rd(daddr)});
            end
        end
        if (ei || !ireq) streak = 0;
        else if (ed && streak < SMAX) streak++;
        @(posedge clk);
        run_m = resetn;
        @(negedge clk);
    endtask

    task automatic idle(output logic [31:0] rd, output bit ook);
        bit oi, od;
        step(0, 0, 0, 0, 0, 0, 0, oi, od, ook, rd);
    endtask

    initial begin
        bit          oi, od, ook, ip, dp, pwr, got_i;
        logic [31:0] rd, ia, da, dwd;
        logic [3:0]  dst;
        logic [31:0] fa[3];
        logic [31:0] fe[3];
        logic [9:0]  pat;
        int          n;
        fa[0] = 32'h1c00_0000; fa[1] = 32'h1c00_0004; fa[2] = 32'h1c00_0008;
        fe[0] = 32'h465a_a5a5; fe[1] = 32'h465a_a5a1; fe[2] = 32'h465a_a5ad;
        pat = 10'b10_0001_0000;

        // Reset state
        repeat (2) @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
        #1;
        chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_we", sram_we, 4'h0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        idle(rd, ook);
        idle(rd, ook);

        // Fetch only, back-to-back
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1, fa[i], 0, 0, 0, 0, 0, oi, od, ook, rd);
            else       idle(rd, ook);
            if (i < 3) chk("fetch_addr_ok", oi, 1'b1);
            if (i > 0) chk("fetch_rdata", rd, fe[i-1]);
        end

        // Contention, both held for 10 cycles
        idle(rd, ook);
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h1c00_0010, 1, 0, 0, 32'h40 + 32'(i * 4), 0, oi, od, ook, rd);
            chk("contend_grant_i", oi, pat[i]);
            chk("contend_grant_d", od, !pat[i]);
        end
        idle(rd, ook);

        // Store then load same address
        step(0, 0, 1, 1, 4'hf, 32'h100, 32'hdead_beef, oi, od, ook, rd);
        step(0, 0, 1, 0, 4'h0, 32'h100, 0, oi, od, ook, rd);
        chk("store_data_ok", ook, 1'b1);
        idle(rd, ook);
        chk("store_load", rd, 32'hdead_beef);

        // Partial strobe, then zero strobe
        step(0, 0, 1, 1, 4'hf, 32'h100, 32'hffff_ffff, oi, od, ook, rd);
        step(0, 0, 1, 1, 4'h3, 32'h100, 32'h1234_5678, oi, od, ook, rd);
        step(0, 0, 1, 0, 4'h0, 32'h100, 0, oi, od, ook, rd);
        idle(rd, ook);
        chk("partial_strobe", rd, 32'hffff_5678);
        step(0, 0, 1, 1, 4'h0, 32'h100, 32'h0, oi, od, ook, rd);
        step(0, 0, 1, 0, 4'h0, 32'h100, 0, oi, od, ook, rd);
        chk("zero_strobe_data_ok", ook, 1'b1);
        idle(rd, ook);
        chk("zero_strobe_mem", rd, 32'hffff_5678);

        // Late inst request during a data stream
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 0, 32'h80, 0, oi, od, ook, rd);
        n = 0;
        got_i = 1'b0;
        for (int i = 0; i < 10 && !got_i; i++) begin
            step(1, 32'h1c00_0020, 1, 0, 0, 32'h84, 0, oi, od, ook, rd);
            if (oi) got_i = 1'b1;
            else if (od) n++;
        end
        chk("late_inst_granted", got_i, 1'b1);
        chk("late_inst_data_grants", n, 4);
        idle(rd, ook);

        // Reset mid-stream with a response in flight
        step(1, 32'h1c00_0030, 0, 0, 0, 0, 0, oi, od, ook, rd);
        resetn = 1'b0;
        #1;
        chk("midrst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        chk("midrst_sram_en", sram_en, 1'b0);
        exp_q.delete();
        streak = 0;
        run_m = 1'b0;
        @(negedge clk);
        step(1, 32'h1c00_0030, 1, 0, 0, 0, 0, oi, od, ook, rd);
        chk("midrst_held_ok", ook, 1'b0);
        resetn = 1'b1;
        step(1, 32'h1c00_0034, 0, 0, 0, 0, 0, oi, od, ook, rd);
        chk("start_cycle1", oi, 1'b0);
        step(1, 32'h1c00_0034, 0, 0, 0, 0, 0, oi, od, ook, rd);
        chk("start_cycle2", oi, 1'b1);
        idle(rd, ook);
        chk("start_data_ok", ook, 1'b1);

        // Random traffic; requests held until accepted, occasionally withdrawn
        ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dst = 0; pwr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; ia = 32'h1c00_0000 + 32'($urandom_range(0, 63) * 4);
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1; pwr = 1'($urandom_range(0, 1));
                da = 32'($urandom_range(0, 63) * 4);
                dwd = $urandom; dst = 4'($urandom_range(0, 15));
            end
            step(ip, ia, dp, pwr, dst, da, dwd, oi, od, ook, rd);
            if (oi) ip = 0;
            if (od) dp = 0;
            if (ip && $urandom_range(0, 15) == 0) ip = 0;
            if (dp && $urandom_range(0, 15) == 0) dp = 0;
        end
        idle(rd, ook);
        idle(rd, ook);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
